// File: rtl/attention_score_stream.sv
// Streaming Q·K^T attention-score engine: P-lane MAC per element, round/scale/saturate,
// optional causal mask, one score per valid/ready handshake in (l, n, l2) row-major order.
module attention_score_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8,
  parameter int P          = 1,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(E)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   causal_en,
  input  logic [3:0]                             scale_shift,
  input  logic [DATA_WIDTH*L*N*E-1:0]            Q_in,
  input  logic [DATA_WIDTH*L*N*E-1:0]            K_in,
  output logic                                   busy,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [(L > 1 ? $clog2(L) : 1)-1:0]     out_row,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0]     out_head,
  output logic [(L > 1 ? $clog2(L) : 1)-1:0]     out_col,
  output logic                                   out_last,
  output logic                                   done
);

  localparam int DW    = DATA_WIDTH;
  localparam int BEATS = E / P;
  localparam int RW    = (L > 1) ? $clog2(L) : 1;
  localparam int HW    = (N > 1) ? $clog2(N) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int QW    = DW * L * N * E;
  localparam int QIW   = (QW > 1) ? $clog2(QW) : 1;
  localparam int WIDE  = ACC_WIDTH + 1;

  localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SAT_MIN = {{(WIDE-DW+1){1'b1}}, {(DW-1){1'b0}}};

  if (E % P != 0) begin : g_bad_lanes
    $error("attention_score_stream: E must be a multiple of P");
  end

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [QW-1:0]                q_r, k_r;
  logic                         causal_r;
  logic [3:0]                   shift_r;
  logic [RW-1:0]                row_q, col_q;
  logic [HW-1:0]                head_q;
  logic [BW-1:0]                beat_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, lane_sum, acc_sum, prod;
  logic signed [DW-1:0]         q_e, k_e;
  logic [QIW-1:0]               q_idx, k_idx;
  logic                         masked, last_beat, elem_last;
  logic [7:0]                   sh;
  logic signed [WIDE-1:0]       rnd, rounded, shifted;
  logic [DW-1:0]                result;

  assign masked    = causal_r && (col_q > row_q);
  assign last_beat = masked || (beat_q == BW'(BEATS-1));
  assign elem_last = (row_q == RW'(L-1)) && (head_q == HW'(N-1)) && (col_q == RW'(L-1));

  // NOTE: every always_comb output gets a default before any branch or loop, so no latch can form.
  always_comb begin
    lane_sum = '0;
    q_idx    = '0;
    k_idx    = '0;
    q_e      = '0;
    k_e      = '0;
    prod     = '0;
    for (int p = 0; p < P; p++) begin
      q_idx    = QIW'((((int'(row_q) * N + int'(head_q)) * E) + int'(beat_q) * P + p) * DW);
      k_idx    = QIW'((((int'(col_q) * N + int'(head_q)) * E) + int'(beat_q) * P + p) * DW);
      q_e      = q_r[q_idx +: DW];
      k_e      = k_r[k_idx +: DW];
      prod     = ACC_WIDTH'(q_e) * ACC_WIDTH'(k_e);
      lane_sum = lane_sum + prod;
    end
    acc_sum = acc_q + lane_sum;
  end

  // Round half up at bit sh-1, then arithmetic shift and clamp to the score range.
  always_comb begin
    sh      = 8'(FRAC_BITS) + {4'd0, shift_r};
    rnd     = (sh == 8'd0) ? '0 : (WIDE'(1) <<< (sh - 8'd1));
    rounded = WIDE'(acc_sum) + rnd;
    shifted = rounded >>> sh;
    if (shifted > SAT_MAX)      result = OUT_MAX;
    else if (shifted < SAT_MIN) result = OUT_MIN;
    else                        result = shifted[DW-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (last_beat) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = out_last ? S_DONE : S_MAC;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the Q/K operand copies carry no reset; they are only read after a start reloads them.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      q_r <= Q_in;
      k_r <= K_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      causal_r <= 1'b0;
      shift_r  <= '0;
      row_q    <= '0;
      head_q   <= '0;
      col_q    <= '0;
      beat_q   <= '0;
      acc_q    <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          causal_r <= causal_en;
          shift_r  <= scale_shift;
          row_q    <= '0;
          head_q   <= '0;
          col_q    <= '0;
          beat_q   <= '0;
          acc_q    <= '0;
        end
        S_MAC: if (last_beat) begin
          out_data <= masked ? OUT_MIN : result;
          out_last <= elem_last;
        end else begin
          acc_q  <= acc_sum;
          beat_q <= beat_q + 1'b1;
        end
        S_OUT: if (out_ready) begin
          acc_q  <= '0;
          beat_q <= '0;
          if (out_last) begin
            out_last <= 1'b0;
            row_q    <= '0;
            head_q   <= '0;
            col_q    <= '0;
          end else if (col_q == RW'(L-1)) begin
            col_q <= '0;
            if (head_q == HW'(N-1)) begin
              head_q <= '0;
              row_q  <= row_q + 1'b1;
            end else begin
              head_q <= head_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign out_row   = row_q;
  assign out_head  = head_q;
  assign out_col   = col_q;

endmodule

// File: tb/tb_attention_score_stream.sv
// Bench for attention_score_stream: table of uniform Q/K vectors, scoreboard of expected
// (data, tags, handshake spacing) per element, plus reset, P=2 latency and backpressure sequences.
module tb_attention_score_stream;

  localparam int DW = 16, L = 8, N = 1, E = 8, NE = L*N*E, RW = 3, HW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, start_p2, causal_en, out_ready;
  logic [3:0]         scale_shift;
  logic [DW*NE-1:0]   Q_in, K_in;
  logic               busy, out_valid, out_last, done;
  logic [DW-1:0]      out_data;
  logic [RW-1:0]      out_row, out_col;
  logic [HW-1:0]      out_head;
  logic               p2_busy, p2_valid, p2_last, p2_done;
  logic [DW-1:0]      p2_data;
  logic [RW-1:0]      p2_row, p2_col;
  logic [HW-1:0]      p2_head;

  attention_score_stream #(.DATA_WIDTH(DW), .FRAC_BITS(8), .L(L), .N(N), .E(E), .P(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .causal_en(causal_en), .scale_shift(scale_shift),
    .Q_in(Q_in), .K_in(K_in), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_head(out_head), .out_col(out_col),
    .out_last(out_last), .done(done)
  );

  attention_score_stream #(.DATA_WIDTH(DW), .FRAC_BITS(8), .L(L), .N(N), .E(E), .P(2)) u_dut_p2 (
    .clk(clk), .rst(rst), .start(start_p2), .causal_en(causal_en), .scale_shift(scale_shift),
    .Q_in(Q_in), .K_in(K_in), .busy(p2_busy), .out_valid(p2_valid), .out_ready(1'b1),
    .out_data(p2_data), .out_row(p2_row), .out_head(p2_head), .out_col(p2_col),
    .out_last(p2_last), .done(p2_done)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] k;
    logic        causal;
    logic [3:0]  shift;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0]         data;
    logic [RW+HW+RW:0]   tag;
    int                  gap;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input vec_t v);
    Q_in        = {NE{v.q}};
    K_in        = {NE{v.k}};
    causal_en   = v.causal;
    scale_shift = v.shift;
  endtask

  task automatic push_stream(input vec_t v);
    exp_t e;
    logic m, lastb;
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int l2 = 0; l2 < L; l2++) begin
          m      = v.causal && (l2 > l);
          lastb  = (l == L-1) && (n == N-1) && (l2 == L-1);
          e.data = m ? 16'h8000 : v.exp;
          e.tag  = {RW'(l), HW'(n), RW'(l2), lastb};
          e.gap  = m ? 2 : E + 1;
          sb.push_back(e);
        end
  endtask

  // Called at a negedge; returns at the negedge just after the edge that sampled start.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input bit timed, input bit rnd_ready, input bit stall, input bit busy_start);
    int j = 0, prev_hs = 0, popped = 0, stall_left = 5;
    while (sb.size() > 0 && j < 5000) begin
      out_ready = 1'b1;
      if (stall && popped == 3 && stall_left > 0 && out_valid) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rnd_ready && popped > 3) begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (busy_start && j == 30) begin
        start = 1'b1;
        Q_in  = {NE{16'h7FFF}};
      end else begin
        start = 1'b0;
      end
      if (out_valid) begin
        check("data", out_data, sb[0].data);
        check("tags", {out_row, out_head, out_col, out_last}, sb[0].tag);
        if (out_ready) begin
          if (timed) check("handshake_gap", j + 1 - prev_hs, sb[0].gap);
          prev_hs = j + 1;
          void'(sb.pop_front());
          popped++;
        end
      end
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      check("stream_timeout_left", sb.size(), 0);
      sb.delete();
    end
    out_ready = 1'b1;
    check("done_pulse", {done, busy, out_valid}, 3'b110);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", {done, busy, out_valid}, 3'b000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int j;
    vecs[0] = '{16'h0100, 16'h0100, 1'b0, 4'd0,  16'h0800};
    vecs[1] = '{16'h0100, 16'h0100, 1'b1, 4'd0,  16'h0800};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 1'b0, 4'd0,  16'h7FFF};
    vecs[3] = '{16'h7FFF, 16'h8000, 1'b0, 4'd0,  16'h8000};
    vecs[4] = '{16'h0001, 16'h0010, 1'b0, 4'd0,  16'h0001};
    vecs[5] = '{16'h0001, 16'hFFF0, 1'b0, 4'd0,  16'h0000};
    vecs[6] = '{16'h0080, 16'h0080, 1'b0, 4'd1,  16'h0100};
    vecs[7] = '{16'h0100, 16'hFF00, 1'b0, 4'd0,  16'hF800};
    vecs[8] = '{16'h7FFF, 16'h7FFF, 1'b0, 4'd15, 16'h0400};

    rst = 1'b1; start = 1'b0; start_p2 = 1'b0; out_ready = 1'b1;
    load(vecs[0]);
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, out_valid, out_data, out_row, out_head, out_col, out_last, done}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a stream, then a fresh stream from (0,0,0) below.
    pulse_start();
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", {busy, out_valid, out_data, out_row, out_head, out_col, out_last, done}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, out_valid, out_data, out_row, out_head, out_col, out_last, done}, '0);

    for (int i = 0; i < 9; i++) begin
      load(vecs[i]);
      push_stream(vecs[i]);
      pulse_start();
      run_stream(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // P=2 instance: first valid one edge after E/P MAC beats.
    load(vecs[0]);
    start_p2 = 1'b1;
    @(negedge clk);
    start_p2 = 1'b0;
    j = 0;
    while (!p2_valid && j < 100) begin
      @(negedge clk);
      j++;
    end
    check("p2_first_valid_edge", j + 1, E/2 + 1);
    check("p2_first_data", p2_data, 16'h0800);
    j = 0;
    while (p2_busy && j < 2000) begin
      @(negedge clk);
      j++;
    end
    check("p2_finished", p2_busy, 1'b0);

    // Backpressure: stall element 3, then random ready; a start pulsed mid-stream is ignored.
    load(vecs[7]);
    push_stream(vecs[7]);
    pulse_start();
    run_stream(1'b0, 1'b1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
